// File: rtl/stack_op_sequencer_if.sv
// rtl/stack_op_sequencer_if.sv - 16-bit stack memory port between the sequencer and data memory
interface stack_op_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - CALL/RET/RTI/interrupt stack sequencer; optional STACK_LIMIT_CHECK_EN adds stack fault detection
module stack_op_sequencer #(
    parameter logic [31:0] SP_INIT    = 32'h0000_0FFF,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0002,
    parameter logic [31:0] SP_LIMIT   = 32'h0000_0F00
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        call_req,
    input  logic                        ret_req,
    input  logic                        rti_req,
    input  logic                        int_req,
    input  logic [31:0]                 pc_in,
    input  logic [31:0]                 target_in,
    input  logic [2:0]                  flags_in,
    stack_op_sequencer_if.master        mem,
    output logic [31:0]                 sp_out,
    output logic                        stall,
    output logic                        pc_load,
    output logic [31:0]                 pc_load_value,
    output logic                        flags_load,
    output logic [2:0]                  flags_load_value,
    output logic                        int_ack,
    output logic                        busy,
    output logic                        stack_fault
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        PUSH_FL,
        POP_FL,
        POP_LO,
        POP_HI,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_CALL,
        OP_INT,
        OP_RET,
        OP_RTI
    } op_t;

`ifdef STACK_LIMIT_CHECK_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t      state, state_n;
    op_t         op, op_n;
    logic [31:0] sp;
    logic        int_pending;
    logic [31:0] pc_q;
    logic [31:0] target_q;
    logic [2:0]  flags_q;
    logic [15:0] hi_q;
    logic [15:0] lo_q;
    logic [2:0]  pop_flags_q;

    logic        int_go;
    logic        any_req;
    logic        is_push;
    logic        is_pop;
    logic        fault_beat;
    logic        beat;
    logic        beat_done;

    // A pending or freshly arriving interrupt outranks every decoded request.
    assign int_go  = int_pending | int_req;
    assign any_req = int_go | rti_req | ret_req | call_req;

    assign is_push = (state == PUSH_HI) || (state == PUSH_LO) || (state == PUSH_FL);
    assign is_pop  = (state == POP_FL) || (state == POP_LO) || (state == POP_HI);

    // Limit check folds to zero when the feature is not built in.
    assign fault_beat = LIMIT_EN && ((is_push && (sp < SP_LIMIT)) || (is_pop && (sp == SP_INIT)));

    assign beat      = (is_push || is_pop) && !fault_beat;
    assign beat_done = beat && mem.mem_ack;

    assign busy   = (state != IDLE);
    assign stall  = busy || any_req;
    assign sp_out = sp;

    // FSM state and operation register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op    <= OP_CALL;
        end else begin
            state <= state_n;
            op    <= op_n;
        end
    end

    // Next state: request arbitration in IDLE, beat-by-beat advance otherwise.
    always_comb begin
        state_n = state;
        op_n    = op;
        case (state)
            IDLE: begin
                if (int_go) begin
                    state_n = PUSH_HI;
                    op_n    = OP_INT;
                end else if (rti_req) begin
                    state_n = POP_FL;
                    op_n    = OP_RTI;
                end else if (ret_req) begin
                    state_n = POP_LO;
                    op_n    = OP_RET;
                end else if (call_req) begin
                    state_n = PUSH_HI;
                    op_n    = OP_CALL;
                end
            end
            PUSH_HI: begin
                if (fault_beat)     state_n = IDLE;
                else if (beat_done) state_n = PUSH_LO;
            end
            PUSH_LO: begin
                if (fault_beat)     state_n = IDLE;
                else if (beat_done) state_n = (op == OP_INT) ? PUSH_FL : DONE;
            end
            PUSH_FL: begin
                if (fault_beat)     state_n = IDLE;
                else if (beat_done) state_n = DONE;
            end
            POP_FL: begin
                if (fault_beat)     state_n = IDLE;
                else if (beat_done) state_n = POP_LO;
            end
            POP_LO: begin
                if (fault_beat)     state_n = IDLE;
                else if (beat_done) state_n = POP_HI;
            end
            POP_HI: begin
                if (fault_beat)     state_n = IDLE;
                else if (beat_done) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Memory beat outputs: pushes write at sp, pops read one above sp.
    always_comb begin
        mem.mem_req   = beat;
        mem.mem_we    = is_push;
        mem.mem_addr  = is_pop ? (sp + 32'd1) : sp;
        mem.mem_wdata = 16'h0000;
        case (state)
            PUSH_HI: mem.mem_wdata = pc_q[31:16];
            PUSH_LO: mem.mem_wdata = pc_q[15:0];
            PUSH_FL: mem.mem_wdata = {13'b0, flags_q};
            default: mem.mem_wdata = 16'h0000;
        endcase
    end

    // Redirect and completion strobes exist only in the single DONE cycle.
    always_comb begin
        pc_load          = 1'b0;
        pc_load_value    = 32'h0000_0000;
        flags_load       = 1'b0;
        flags_load_value = 3'b000;
        int_ack          = 1'b0;
        if (state == DONE) begin
            pc_load = 1'b1;
            case (op)
                OP_CALL: pc_load_value = target_q;
                OP_INT:  pc_load_value = INT_VECTOR;
                default: pc_load_value = {hi_q, lo_q};
            endcase
            if (op == OP_RTI) begin
                flags_load       = 1'b1;
                flags_load_value = pop_flags_q;
            end
            int_ack = (op == OP_INT);
        end
    end

    // Stack pointer moves only on acknowledged beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= SP_INIT;
        end else if (beat_done) begin
            sp <= is_push ? (sp - 32'd1) : (sp + 32'd1);
        end
    end

    // Interrupt latch: cleared when IDLE hands off to the interrupt sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_pending <= 1'b0;
        end else if ((state == IDLE) && int_go) begin
            int_pending <= 1'b0;
        end else if (int_req) begin
            int_pending <= 1'b1;
        end
    end

    // Operands are frozen in the detect cycle so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= 32'h0000_0000;
            target_q <= 32'h0000_0000;
            flags_q  <= 3'b000;
        end else if ((state == IDLE) && any_req) begin
            pc_q     <= pc_in;
            target_q <= target_in;
            flags_q  <= flags_in;
        end
    end

    // Popped words collect here until the DONE redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q        <= 16'h0000;
            lo_q        <= 16'h0000;
            pop_flags_q <= 3'b000;
        end else if (beat_done) begin
            case (state)
                POP_FL:  pop_flags_q <= mem.mem_rdata[2:0];
                POP_LO:  lo_q        <= mem.mem_rdata;
                POP_HI:  hi_q        <= mem.mem_rdata;
                default: ;
            endcase
        end
    end

`ifdef STACK_LIMIT_CHECK_EN
    // Sticky fault: set by any out-of-range beat, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stack_fault <= 1'b0;
        end else if (fault_beat) begin
            stack_fault <= 1'b1;
        end
    end
`else
    assign stack_fault = 1'b0;
`endif

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb/tb_stack_op_sequencer.sv - scoreboard bench for stack_op_sequencer
module tb_stack_op_sequencer;

    localparam logic [31:0] SP_INIT    = 32'h0000_0FFF;
    localparam logic [31:0] INT_VECTOR = 32'h0000_0002;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [15:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] pc;
        logic        fl_load;
        logic [2:0]  fl;
        logic        iack;
        int          t;
    } load_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        call_req = 1'b0;
    logic        ret_req = 1'b0;
    logic        rti_req = 1'b0;
    logic        int_req = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] target_in = 32'h0;
    logic [2:0]  flags_in = 3'b000;
    logic [31:0] sp_out;
    logic        stall;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        flags_load;
    logic [2:0]  flags_load_value;
    logic        int_ack;
    logic        busy;
    logic        stack_fault;

    stack_op_sequencer_if mem ();

    stack_op_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .call_req         (call_req),
        .ret_req          (ret_req),
        .rti_req          (rti_req),
        .int_req          (int_req),
        .pc_in            (pc_in),
        .target_in        (target_in),
        .flags_in         (flags_in),
        .mem              (mem),
        .sp_out           (sp_out),
        .stall            (stall),
        .pc_load          (pc_load),
        .pc_load_value    (pc_load_value),
        .flags_load       (flags_load),
        .flags_load_value (flags_load_value),
        .int_ack          (int_ack),
        .busy             (busy),
        .stack_fault      (stack_fault)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    ack_mode = 0;
    int    acnt = 0;
    beat_t beat_q[$];
    load_t load_q[$];
    logic [15:0] mem_arr [0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: write on acknowledged push, combinational read.
    always @(posedge clk) begin
        if (mem.mem_req && mem.mem_ack && mem.mem_we)
            mem_arr[mem.mem_addr[11:0]] <= mem.mem_wdata;
    end
    assign mem.mem_rdata = mem_arr[mem.mem_addr[11:0]];

    // Acknowledge: always 1, or one cycle in three.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            acnt = (acnt == 2) ? 0 : acnt + 1;
            mem.mem_ack = (ack_mode == 0) || (acnt == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_w(input logic [31:0] a, input logic [15:0] d);
        beat_t b;
        b.we = 1'b1; b.addr = a; b.wdata = d;
        beat_q.push_back(b);
    endtask

    task automatic exp_r(input logic [31:0] a);
        beat_t b;
        b.we = 1'b0; b.addr = a; b.wdata = 16'h0;
        beat_q.push_back(b);
    endtask

    task automatic exp_ld(input logic [31:0] pc, input logic fl_ld, input logic [2:0] fl,
                          input logic iack, input int t);
        load_t l;
        l.pc = pc; l.fl_load = fl_ld; l.fl = fl; l.iack = iack; l.t = t;
        load_q.push_back(l);
    endtask

    // Monitor: samples 3 time units after each rising edge.
    logic        prev_pending = 1'b0;
    logic        prev_acked = 1'b0;
    logic [31:0] prev_sp = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    logic [15:0] prev_wdata = 16'h0;
    logic        prev_we = 1'b0;
    initial begin
        beat_t b;
        load_t l;
        forever begin
            @(posedge clk);
            #3;
            if (!rst) begin
                if (mem.mem_req && mem.mem_ack) begin
                    if (beat_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got addr %h we %0d, expected no beat", mem.mem_addr, mem.mem_we);
                    end else begin
                        b = beat_q.pop_front();
                        chk("beat_we", {31'b0, mem.mem_we}, {31'b0, b.we});
                        chk("beat_addr", mem.mem_addr, b.addr);
                        if (b.we) chk("beat_wdata", {16'b0, mem.mem_wdata}, {16'b0, b.wdata});
                    end
                end
                if (pc_load) begin
                    if (load_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pc_load: got %h, expected no redirect", pc_load_value);
                    end else begin
                        l = load_q.pop_front();
                        chk("pc_load_value", pc_load_value, l.pc);
                        chk("flags_load", {31'b0, flags_load}, {31'b0, l.fl_load});
                        if (l.fl_load) chk("flags_load_value", {29'b0, flags_load_value}, {29'b0, l.fl});
                        chk("int_ack", {31'b0, int_ack}, {31'b0, l.iack});
                        if (l.t >= 0) chk("pc_load_cycle", cyc, l.t);
                    end
                end
                if ((flags_load || int_ack) && !pc_load) begin
                    checks++; errors++;
                    $display("FAIL stray_strobe: got flags_load %0d int_ack %0d, expected 0 without pc_load", flags_load, int_ack);
                end
                if (prev_pending) begin
                    chk("hold_req", {31'b0, mem.mem_req}, 32'd1);
                    chk("hold_addr", mem.mem_addr, prev_addr);
                    chk("hold_wdata", {16'b0, mem.mem_wdata}, {16'b0, prev_wdata});
                    chk("hold_we", {31'b0, mem.mem_we}, {31'b0, prev_we});
                end
                if (sp_out !== prev_sp) chk("sp_moves_on_ack", {31'b0, prev_acked}, 32'd1);
                if (busy) chk("stall_while_busy", {31'b0, stall}, 32'd1);
            end
            prev_pending = !rst && mem.mem_req && !mem.mem_ack;
            prev_acked   = mem.mem_req && mem.mem_ack;
            prev_sp      = sp_out;
            prev_addr    = mem.mem_addr;
            prev_wdata   = mem.mem_wdata;
            prev_we      = mem.mem_we;
        end
    end

    // Present one request for the detect cycle, then scramble the operands.
    task automatic start(input logic c, input logic r, input logic ti, input logic i,
                         input logic [31:0] pc, input logic [31:0] tg, input logic [2:0] fl,
                         input logic [31:0] epc, input logic efl_ld, input logic [2:0] efl,
                         input logic eiack, input int lat);
        int t;
        @(negedge clk);
        call_req = c; ret_req = r; rti_req = ti; int_req = i;
        pc_in = pc; target_in = tg; flags_in = fl;
        t = cyc;
        exp_ld(epc, efl_ld, efl, eiack, (lat < 0) ? -1 : t + lat);
        @(negedge clk);
        call_req = 1'b0; ret_req = 1'b0; rti_req = 1'b0; int_req = 1'b0;
        pc_in = 32'hDEAD_BEEF; target_in = 32'hBAD0_BAD0; flags_in = 3'b111;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || stall) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy %0d stall %0d, expected idle within 200 cycles", busy, stall);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sp", sp_out, SP_INIT);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_mem_req", {31'b0, mem.mem_req}, 32'd0);
        chk("rst_pc_load", {31'b0, pc_load}, 32'd0);
        chk("rst_flags_load", {31'b0, flags_load}, 32'd0);
        chk("rst_int_ack", {31'b0, int_ack}, 32'd0);
        chk("rst_pc_load_value", pc_load_value, 32'd0);
        chk("rst_flags_load_value", {29'b0, flags_load_value}, 32'd0);
        chk("rst_stack_fault", {31'b0, stack_fault}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CALL
        exp_w(32'h0FFF, 16'h0001);
        exp_w(32'h0FFE, 16'h2345);
        start(1, 0, 0, 0, 32'h0001_2345, 32'h0000_0100, 3'b000, 32'h0000_0100, 0, 3'b000, 0, 3);
        wait_idle();
        chk("call_sp", sp_out, 32'h0FFD);

        // RET
        exp_r(32'h0FFE);
        exp_r(32'h0FFF);
        start(0, 1, 0, 0, 32'h0, 32'h0, 3'b000, 32'h0001_2345, 0, 3'b000, 0, 3);
        wait_idle();
        chk("ret_sp", sp_out, 32'h0FFF);

        // INT
        exp_w(32'h0FFF, 16'h0000);
        exp_w(32'h0FFE, 16'hABCD);
        exp_w(32'h0FFD, 16'h0005);
        start(0, 0, 0, 1, 32'h0000_ABCD, 32'h0, 3'b101, INT_VECTOR, 0, 3'b000, 1, 4);
        wait_idle();
        chk("int_sp", sp_out, 32'h0FFC);

        // RTI
        exp_r(32'h0FFD);
        exp_r(32'h0FFE);
        exp_r(32'h0FFF);
        start(0, 0, 1, 0, 32'h0, 32'h0, 3'b000, 32'h0000_ABCD, 1, 3'b101, 0, 4);
        wait_idle();
        chk("rti_sp", sp_out, 32'h0FFF);

        // Wait states
        ack_mode = 1;
        exp_w(32'h0FFF, 16'h1234);
        exp_w(32'h0FFE, 16'h5678);
        start(1, 0, 0, 0, 32'h1234_5678, 32'h0000_0200, 3'b000, 32'h0000_0200, 0, 3'b000, 0, -1);
        wait_idle();
        chk("ws_call_sp", sp_out, 32'h0FFD);
        exp_r(32'h0FFE);
        exp_r(32'h0FFF);
        start(0, 1, 0, 0, 32'h0, 32'h0, 3'b000, 32'h1234_5678, 0, 3'b000, 0, -1);
        wait_idle();
        chk("ws_ret_sp", sp_out, 32'h0FFF);
        ack_mode = 0;
        repeat (3) @(negedge clk);

        // Simultaneous CALL and INT: INT first, held CALL after DONE
        exp_w(32'h0FFF, 16'h0000);
        exp_w(32'h0FFE, 16'h1111);
        exp_w(32'h0FFD, 16'h0002);
        exp_w(32'h0FFC, 16'h0000);
        exp_w(32'h0FFB, 16'h1111);
        @(negedge clk);
        call_req = 1'b1; int_req = 1'b1;
        pc_in = 32'h0000_1111; target_in = 32'h0000_0300; flags_in = 3'b010;
        t = cyc;
        exp_ld(INT_VECTOR, 0, 3'b000, 1, t + 4);
        exp_ld(32'h0000_0300, 0, 3'b000, 0, t + 8);
        @(negedge clk);
        int_req = 1'b0;
        while (cyc < t + 6) @(negedge clk);
        call_req = 1'b0;
        wait_idle();
        chk("both_sp", sp_out, 32'h0FFA);
        exp_r(32'h0FFB);
        exp_r(32'h0FFC);
        start(0, 1, 0, 0, 32'h0, 32'h0, 3'b000, 32'h0000_1111, 0, 3'b000, 0, 3);
        wait_idle();
        chk("both_ret_sp", sp_out, 32'h0FFC);
        exp_r(32'h0FFD);
        exp_r(32'h0FFE);
        exp_r(32'h0FFF);
        start(0, 0, 1, 0, 32'h0, 32'h0, 3'b000, 32'h0000_1111, 1, 3'b010, 0, 4);
        wait_idle();
        chk("both_rti_sp", sp_out, 32'h0FFF);

        // Reset during PUSH_LO
        exp_w(32'h0FFF, 16'h5555);
        exp_w(32'h0FFE, 16'h6666);
        @(negedge clk);
        call_req = 1'b1; pc_in = 32'h5555_6666; target_in = 32'h0000_0400;
        @(negedge clk);
        call_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_sp", sp_out, 32'h0FFF);
        chk("abort_mem_req", {31'b0, mem.mem_req}, 32'd0);
        chk("abort_pc_load", {31'b0, pc_load}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

`ifdef STACK_LIMIT_CHECK_EN
        // RET on an empty stack faults without touching memory
        @(negedge clk);
        ret_req = 1'b1;
        @(negedge clk);
        ret_req = 1'b0;
        chk("fault_no_req", {31'b0, mem.mem_req}, 32'd0);
        @(negedge clk);
        chk("fault_flag", {31'b0, stack_fault}, 32'd1);
        chk("fault_idle", {31'b0, busy}, 32'd0);
        chk("fault_stall", {31'b0, stall}, 32'd0);
        repeat (4) @(negedge clk);
`else
        chk("no_fault", {31'b0, stack_fault}, 32'd0);
`endif

        chk("beat_q_empty", beat_q.size(), 32'd0);
        chk("load_q_empty", load_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
